// File: rtl/matproc_pkg.sv
// Shared types for the row-streaming matrix engine: opcodes, FSM states and operand-count lookup.
// MATPROC_MUL_EN enables the lane-wise multiply opcode; it is illegal when the macro is undefined.
package matproc_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    MUL = 4'd1,
    ADD = 4'd2,
    SUB = 4'd3,
    SDC = 4'd8,
    SRR = 4'd9,
    SUC = 4'd10,
    SLR = 4'd11,
    AWC = 4'd12,
    AND = 4'd13,
    XWC = 4'd14,
    LOR = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Number of operand matrices an opcode consumes; 0 means no rows are loaded.
  function automatic logic [1:0] rows_needed(input op_e op);
    case (op)
      ADD, SUB, AND, LOR:                rows_needed = 2'd2;
`ifdef MATPROC_MUL_EN
      MUL:                               rows_needed = 2'd2;
`endif
      SDC, SRR, SUC, SLR, AWC, XWC:      rows_needed = 2'd1;
      default:                           rows_needed = 2'd0;
    endcase
  endfunction

  function automatic logic is_legal(input op_e op);
    is_legal = (op == NOP) || (rows_needed(op) != 2'd0);
  endfunction

endpackage

// File: rtl/matproc_if.sv
// Command, operand-row and result-row channels of the matrix engine, plus the illegal-op pulse.
interface matproc_if #(
  parameter int ROW_W = 32
);

  // Every channel transfers on a rising clock edge where valid && ready are both high;
  // the source holds valid and payload until that edge, ready may change freely.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [ROW_W-1:0] cmd_const;

  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_data;

  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_data;

  logic             op_err;

  modport master (
    output cmd_valid, cmd_op, cmd_const, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, op_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_const, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, op_err
  );

endinterface

// File: rtl/matproc_alu.sv
// Combinational whole-matrix operator: flattened A/B operands and a row constant in, result matrix out.
// MATPROC_MUL_EN adds the lane-wise multiplier; without it no multiplier is built.
module matproc_alu
  import matproc_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int ROW_W  = 32,
  parameter int ELEM_W = 8
) (
  input  op_e                   op,
  input  logic [ROWS*ROW_W-1:0] a_flat,
  input  logic [ROWS*ROW_W-1:0] b_flat,
  input  logic [ROW_W-1:0]      const_row,
  output logic [ROWS*ROW_W-1:0] res_flat
);

  localparam int LANES = ROW_W / ELEM_W;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ROW_W-1:0] a_row;
    logic [ROW_W-1:0] b_row;
    logic [ROW_W-1:0] prev_row;
    logic [ROW_W-1:0] next_row;
    logic [ROW_W-1:0] res_row;

    assign a_row = a_flat[r*ROW_W +: ROW_W];
    assign b_row = b_flat[r*ROW_W +: ROW_W];

    // Row moves shift in zeros at the matrix edges.
    if (r == 0) begin : g_first
      assign prev_row = '0;
    end else begin : g_prev
      assign prev_row = a_flat[(r-1)*ROW_W +: ROW_W];
    end

    if (r == ROWS-1) begin : g_last
      assign next_row = '0;
    end else begin : g_next
      assign next_row = a_flat[(r+1)*ROW_W +: ROW_W];
    end

    always_comb begin
      res_row = '0;
      case (op)
        ADD: begin
          for (int k = 0; k < LANES; k++) begin
            res_row[k*ELEM_W +: ELEM_W] = a_row[k*ELEM_W +: ELEM_W] + b_row[k*ELEM_W +: ELEM_W];
          end
        end
        SUB: begin
          for (int k = 0; k < LANES; k++) begin
            res_row[k*ELEM_W +: ELEM_W] = a_row[k*ELEM_W +: ELEM_W] - b_row[k*ELEM_W +: ELEM_W];
          end
        end
`ifdef MATPROC_MUL_EN
        MUL: begin
          for (int k = 0; k < LANES; k++) begin
            res_row[k*ELEM_W +: ELEM_W] = a_row[k*ELEM_W +: ELEM_W] * b_row[k*ELEM_W +: ELEM_W];
          end
        end
`endif
        AND:     res_row = a_row & b_row;
        LOR:     res_row = a_row | b_row;
        AWC:     res_row = a_row & const_row;
        XWC:     res_row = a_row ^ const_row;
        SDC:     res_row = prev_row;
        SUC:     res_row = next_row;
        SRR:     res_row = a_row >> ELEM_W;
        SLR:     res_row = a_row << ELEM_W;
        default: res_row = '0;
      endcase
    end

    assign res_flat[r*ROW_W +: ROW_W] = res_row;
  end

endmodule

// File: rtl/matrix_stream_processor.sv
// Row-streaming matrix engine: accepts a command, loads one or two operand matrices row by row,
// computes in one cycle and drains result rows with backpressure. MATPROC_MUL_EN enables MUL.
module matrix_stream_processor
  import matproc_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int ROW_W  = 32,
  parameter int ELEM_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  matproc_if.slave   bus,
  output state_e     state_dbg
);

  localparam int CNT_W = $clog2(2*ROWS+1);
  localparam int IDX_W = $clog2(ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS-1);

  state_e           state;
  op_e              op_q;
  logic [ROW_W-1:0] const_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic [IDX_W-1:0] wr_idx;
  logic             b_phase;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] nxt_idx;

  logic             cmd_ready_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ROW_W-1:0] out_data_q;
  logic             op_err_q;

  logic [ROW_W-1:0]      a_mem   [ROWS];
  logic [ROW_W-1:0]      b_mem   [ROWS];
  logic [ROW_W-1:0]      res_mem [ROWS];
  logic [ROWS*ROW_W-1:0] a_flat;
  logic [ROWS*ROW_W-1:0] b_flat;
  logic [ROWS*ROW_W-1:0] res_flat;

  op_e        cmd_op_e;
  logic [1:0] need;
  logic       cmd_fire;
  logic       row_fire;
  logic       out_fire;

  assign cmd_op_e = op_e'(bus.cmd_op);
  assign need     = rows_needed(cmd_op_e);
  assign cmd_fire = bus.cmd_valid && cmd_ready_q;
  assign row_fire = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;
  assign nxt_idx  = rd_idx + 1'b1;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.op_err    = op_err_q;
  assign state_dbg     = state;

  for (genvar r = 0; r < ROWS; r++) begin : g_flat
    assign a_flat[r*ROW_W +: ROW_W] = a_mem[r];
    assign b_flat[r*ROW_W +: ROW_W] = b_mem[r];
  end

  matproc_alu #(
    .ROWS   (ROWS),
    .ROW_W  (ROW_W),
    .ELEM_W (ELEM_W)
  ) u_alu (
    .op        (op_q),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .const_row (const_q),
    .res_flat  (res_flat)
  );

  // Operand and result storage carry no reset: they are only read after being fully rewritten.
  always_ff @(posedge clk) begin
    if (row_fire) begin
      if (b_phase) begin
        b_mem[wr_idx] <= bus.in_data;
      end else begin
        a_mem[wr_idx] <= bus.in_data;
      end
    end
    if (state == EXEC) begin
      for (int r = 0; r < ROWS; r++) begin
        res_mem[r] <= res_flat[r*ROW_W +: ROW_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= NOP;
      const_q     <= '0;
      cnt         <= '0;
      last_cnt    <= '0;
      wr_idx      <= '0;
      b_phase     <= 1'b0;
      rd_idx      <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      op_err_q    <= 1'b0;
    end else begin
      op_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            op_q    <= cmd_op_e;
            const_q <= bus.cmd_const;
            cnt     <= '0;
            wr_idx  <= '0;
            b_phase <= 1'b0;
            // NOP and illegal opcodes are swallowed here without touching the row channels.
            if (need == 2'd0) begin
              op_err_q <= !is_legal(cmd_op_e);
            end else begin
              last_cnt    <= (need == 2'd2) ? CNT_W'(2*ROWS) : CNT_W'(ROWS);
              cmd_ready_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (row_fire) begin
            cnt <= cnt + 1'b1;
            if (wr_idx == LAST_IDX) begin
              wr_idx  <= '0;
              b_phase <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
            if (cnt == last_cnt - 1'b1) begin
              in_ready_q <= 1'b0;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          rd_idx      <= '0;
          out_data_q  <= res_flat[ROW_W-1:0];
          out_valid_q <= 1'b1;
          state       <= DRAIN;
        end
        DRAIN: begin
          if (out_fire) begin
            if (rd_idx == LAST_IDX) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              cmd_ready_q <= 1'b1;
              state       <= IDLE;
            end else begin
              rd_idx     <= nxt_idx;
              out_data_q <= res_mem[nxt_idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_processor.sv
// Directed bench for matrix_stream_processor at ROWS=8, ROW_W=32, ELEM_W=8.
module tb_matrix_stream_processor;
  import matproc_pkg::*;

  localparam int ROWS   = 8;
  localparam int ROW_W  = 32;
  localparam int ELEM_W = 8;

  logic   clk = 1'b0;
  logic   reset_n;
  state_e state_dbg;

  int checks = 0;
  int errors = 0;

  logic [ROW_W-1:0] exp_q[$];
  logic [ROW_W-1:0] got_q[$];
  logic [ROW_W-1:0] in_q[$];
  logic [ROW_W-1:0] exp_v;
  logic [ROW_W-1:0] got_v;

  matproc_if #(.ROW_W(ROW_W)) bus();

  matrix_stream_processor #(
    .ROWS   (ROWS),
    .ROW_W  (ROW_W),
    .ELEM_W (ELEM_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [3:0] op, input logic [ROW_W-1:0] c);
    int budget = 50;
    bus.cmd_op    = op;
    bus.cmd_const = c;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    bus.cmd_valid = 1'b0;
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: cmd_ready never high for op %0h", op);
    end
  endtask

  task automatic send_rows();
    int budget;
    while (in_q.size() > 0) begin
      budget = 50;
      bus.in_data  = in_q.pop_front();
      bus.in_valid = 1'b1;
      while (!bus.in_ready && budget > 0) begin
        tick();
        budget--;
      end
      tick();
      bus.in_valid = 1'b0;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL row_timeout: in_ready never high, %0d rows left", in_q.size());
        in_q.delete();
      end
    end
  endtask

  task automatic collect_rows(input int n);
    int budget = 200;
    got_q.delete();
    bus.out_ready = 1'b1;
    while (got_q.size() < n && budget > 0) begin
      if (bus.out_valid) got_q.push_back(bus.out_data);
      tick();
      budget--;
    end
    bus.out_ready = 1'b0;
    if (got_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL collect_timeout: got %0d rows, expected %0d", got_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_const = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err: got %b expected 0", bus.op_err); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    send_cmd(ADD, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h01FF_7F80);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h0101_0180);
    send_rows();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_lat_t1: out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add_exec_in_ready: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_lat_t2: out_valid got %b expected 1", bus.out_valid); end
    checks++; if (state_dbg !== DRAIN) begin errors++; $display("FAIL add_state: got %0d expected %0d", state_dbg, DRAIN); end
    for (int r = 0; r < ROWS; r++) exp_q.push_back(32'h0200_8000);
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL add_row%0d: got %h expected %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_xwc();
    send_cmd(XWC, 32'hFFFF_0000);
    for (int r = 0; r < ROWS; r++) in_q.push_back(ROW_W'(r));
    send_rows();
    // keep a stray row offered: it must not be taken
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_valid = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL xwc_extra_row: in_ready got %b expected 0", bus.in_ready); end
    checks++; if (state_dbg !== EXEC) begin errors++; $display("FAIL xwc_state: got %0d expected %0d", state_dbg, EXEC); end
    for (int r = 0; r < ROWS; r++) exp_q.push_back(32'hFFFF_0000 ^ ROW_W'(r));
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL xwc_row%0d: got %h expected %h", i, got_v, exp_v); end
    end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL xwc_idle_in_ready: got %b expected 0", bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_sdc();
    send_cmd(SDC, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(ROW_W'(r + 1));
    send_rows();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(ROW_W'(r));
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL sdc_row%0d: got %h expected %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_shift();
    send_cmd(SLR, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h1122_3344);
    send_rows();
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== 32'h2233_4400) begin errors++; $display("FAIL slr_row%0d: got %h expected 22334400", i, got_v); end
    end
    send_cmd(SRR, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h1122_3344 + ROW_W'(r));
    send_rows();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(32'h0011_2233);
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL srr_row%0d: got %h expected %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_stall();
    int budget = 400;
    int hs = 0;
    logic prev_stalled = 1'b0;
    logic [ROW_W-1:0] prev_data = '0;
    send_cmd(SUC, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h0000_00A0 | ROW_W'(r));
    send_rows();
    for (int r = 0; r < ROWS - 1; r++) exp_q.push_back(32'h0000_00A0 | ROW_W'(r + 1));
    exp_q.push_back('0);
    got_q.delete();
    while (hs < ROWS && budget > 0) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (prev_stalled) begin
        checks++;
        if (bus.out_data !== prev_data) begin errors++; $display("FAIL stall_hold: got %h expected %h", bus.out_data, prev_data); end
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        hs++;
      end
      prev_stalled = bus.out_valid && !bus.out_ready;
      prev_data    = bus.out_data;
      tick();
      budget--;
    end
    bus.out_ready = 1'b0;
    checks++; if (hs != ROWS) begin errors++; $display("FAIL stall_handshakes: got %0d expected %0d", hs, ROWS); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra_valid: got %b expected 0", bus.out_valid); end
    for (int i = 0; i < ROWS; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL suc_row%0d: got %h expected %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_illegal();
    bus.in_data  = 32'h5555_AAAA;
    bus.in_valid = 1'b1;
    send_cmd(4'h5, '0);
    checks++; if (bus.op_err !== 1'b1) begin errors++; $display("FAIL illegal_op_err: got %b expected 1", bus.op_err); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL illegal_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL illegal_state: got %0d expected %0d", state_dbg, IDLE); end
    tick();
    checks++; if (bus.op_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_len: got %b expected 0", bus.op_err); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL illegal_in_ready2: got %b expected 0", bus.in_ready); end
    send_cmd(NOP, '0);
    checks++; if (bus.op_err !== 1'b0) begin errors++; $display("FAIL nop_op_err: got %b expected 0", bus.op_err); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL nop_state: got %0d expected %0d", state_dbg, IDLE); end
`ifndef MATPROC_MUL_EN
    send_cmd(MUL, '0);
    checks++; if (bus.op_err !== 1'b1) begin errors++; $display("FAIL mul_op_err: got %b expected 1", bus.op_err); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL mul_state: got %0d expected %0d", state_dbg, IDLE); end
`endif
    bus.in_valid = 1'b0;
    send_cmd(ADD, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h0102_0304);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h1010_10FF);
    send_rows();
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== 32'h1112_1303) begin errors++; $display("FAIL post_illegal_row%0d: got %h expected 11121303", i, got_v); end
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(AND, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'hF0F0_1234);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h0FF0_FF00);
    send_rows();
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== 32'h00F0_1200) begin errors++; $display("FAIL and_row%0d: got %h expected 00f01200", i, got_v); end
    end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_cmd_ready: got %b expected 1", bus.cmd_ready); end
    send_cmd(LOR, '0);
    checks++; if (state_dbg !== LOAD) begin errors++; $display("FAIL b2b_state: got %0d expected %0d", state_dbg, LOAD); end
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'hF000_0001);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h0F00_0010);
    send_rows();
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== 32'hFF00_0011) begin errors++; $display("FAIL lor_row%0d: got %h expected ff000011", i, got_v); end
    end
    send_cmd(AWC, 32'h00FF_00FF);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h1234_5678);
    send_rows();
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== 32'h0034_0078) begin errors++; $display("FAIL awc_row%0d: got %h expected 00340078", i, got_v); end
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(ADD, '0);
    for (int r = 0; r < 5; r++) in_q.push_back(32'h7777_7777);
    send_rows();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", state_dbg, IDLE); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    send_cmd(SUB, '0);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h0510_FF00);
    for (int r = 0; r < ROWS; r++) in_q.push_back(32'h0620_0101);
    send_rows();
    collect_rows(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : '0;
      checks++;
      if (got_v !== 32'hFFF0_FEFF) begin errors++; $display("FAIL midrst_sub_row%0d: got %h expected fff0feff", i, got_v); end
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_tail_valid: got %b expected 0", bus.out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_xwc();
    test_sdc();
    test_shift();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
